// File: rtl/sync_fifo_pkg.sv
// Default geometry shared by the FIFO top and its storage array.
package sync_fifo_pkg;
   localparam int DEFAULT_DATA_BITS  = 8;
   localparam int DEFAULT_DEPTH_BITS = 2;
endpackage

// File: rtl/sync_fifo_ram.sv
// Register array for sync_fifo: one synchronous write port, one asynchronous read port.
module sync_fifo_ram
   import sync_fifo_pkg::*;
#(
   parameter int DATA_BITS  = DEFAULT_DATA_BITS,
   parameter int DEPTH_BITS = DEFAULT_DEPTH_BITS
) (
   input  logic                  clock,
   input  logic                  write_en,
   input  logic [DEPTH_BITS-1:0] write_addr,
   input  logic [DATA_BITS-1:0]  write_data,
   input  logic [DEPTH_BITS-1:0] read_addr,
   output logic [DATA_BITS-1:0]  read_data
);
   logic [DATA_BITS-1:0] mem [2**DEPTH_BITS];

   // Contents are deliberately not reset; the pointers alone define validity.
   always_ff @(posedge clock) begin
      if (write_en) begin
         mem[write_addr] <= write_data;
      end
   end

   assign read_data = mem[read_addr];
endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with overflow/underflow error pulses.
// Optional level_o output is enabled by defining FIFO_LEVEL_EN.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DATA_BITS  = DEFAULT_DATA_BITS,
   parameter int DEPTH_BITS = DEFAULT_DEPTH_BITS
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 write_i,
   input  logic [DATA_BITS-1:0] write_data_i,
   output logic                 write_ready_o,
   input  logic                 read_i,
   output logic [DATA_BITS-1:0] read_data_o,
   output logic                 read_ready_o,
`ifdef FIFO_LEVEL_EN
   output logic [DEPTH_BITS:0]  level_o,
`endif
   output logic                 error_underflow_o,
   output logic                 error_overflow_o
);
   localparam int PTR_BITS = DEPTH_BITS + 1;

   logic [PTR_BITS-1:0] wr_ptr;
   logic [PTR_BITS-1:0] rd_ptr;
   logic                empty;
   logic                full;
   logic                write_accept;
   logic                read_accept;

   // The extra MSB distinguishes full from empty when the low bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]) &&
                  (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]);

   // A read frees a slot in the same cycle, so a write into a full FIFO is fine alongside it.
   assign write_accept = write_i & (~full | read_i);
   assign read_accept  = read_i & ~empty;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (write_accept) begin
            wr_ptr <= wr_ptr + PTR_BITS'(1);
         end
         if (read_accept) begin
            rd_ptr <= rd_ptr + PTR_BITS'(1);
         end
      end
   end

   sync_fifo_ram #(
      .DATA_BITS  (DATA_BITS),
      .DEPTH_BITS (DEPTH_BITS)
   ) u_ram (
      .clock      (clock),
      .write_en   (write_accept),
      .write_addr (wr_ptr[DEPTH_BITS-1:0]),
      .write_data (write_data_i),
      .read_addr  (rd_ptr[DEPTH_BITS-1:0]),
      .read_data  (read_data_o)
   );

   assign write_ready_o     = ~full;
   assign read_ready_o      = ~empty;
   assign error_underflow_o = read_i & empty;
   assign error_overflow_o  = write_i & full & ~read_i;

`ifdef FIFO_LEVEL_EN
   assign level_o = wr_ptr - rd_ptr;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (DATA_BITS=8, DEPTH_BITS=2) against a queue model.
module tb_sync_fifo;
   logic       clock = 1'b0;
   logic       reset;
   logic       write_i;
   logic [7:0] write_data_i;
   logic       write_ready_o;
   logic       read_i;
   logic [7:0] read_data_o;
   logic       read_ready_o;
   logic       error_underflow_o;
   logic       error_overflow_o;
`ifdef FIFO_LEVEL_EN
   logic [2:0] level_o;
`endif

   int errors = 0;
   int checks = 0;
   logic [7:0] q[$];

   always #5 clock = ~clock;

   sync_fifo #(.DATA_BITS(8), .DEPTH_BITS(2)) dut (
      .clock             (clock),
      .reset             (reset),
      .write_i           (write_i),
      .write_data_i      (write_data_i),
      .write_ready_o     (write_ready_o),
      .read_i            (read_i),
      .read_data_o       (read_data_o),
      .read_ready_o      (read_ready_o),
`ifdef FIFO_LEVEL_EN
      .level_o           (level_o),
`endif
      .error_underflow_o (error_underflow_o),
      .error_overflow_o  (error_overflow_o)
   );

   // Drive inputs after the falling edge, then let combinational outputs settle.
   task automatic drive(input logic w, input logic [7:0] d, input logic r);
      @(negedge clock);
      write_i      = w;
      write_data_i = d;
      read_i       = r;
      #1;
   endtask

   // Advance one rising edge and apply the FIFO rules to the reference queue.
   task automatic commit();
      int  old;
      bit  do_pop;
      bit  do_push;
      @(posedge clock);
      if (reset) begin
         q.delete();
      end else begin
         old     = q.size();
         do_pop  = read_i && old > 0;
         do_push = write_i && (old < 4 || read_i);
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(write_data_i);
      end
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; write_i = 1'b0; read_i = 1'b0; write_data_i = '0;
      q.delete();
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      drive(0, 0, 0);
      checks++; if (read_ready_o !== 1'b0) begin errors++; $display("FAIL reset_read_ready got=%b exp=0", read_ready_o); end
      checks++; if (write_ready_o !== 1'b1) begin errors++; $display("FAIL reset_write_ready got=%b exp=1", write_ready_o); end
      checks++; if ({error_underflow_o, error_overflow_o} !== 2'b00) begin errors++; $display("FAIL reset_errors got=%b exp=00", {error_underflow_o, error_overflow_o}); end
`ifdef FIFO_LEVEL_EN
      checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level_o); end
`endif
   endtask

   task automatic test_single();
      drive(1, 8'd65, 0); commit();
      drive(0, 0, 0); commit();
      drive(0, 0, 1);
      checks++; if (read_data_o !== 8'd65) begin errors++; $display("FAIL single_data got=%0d exp=65", read_data_o); end
      checks++; if (read_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", read_ready_o); end
      commit();
      drive(0, 0, 0);
      checks++; if (read_ready_o !== 1'b0) begin errors++; $display("FAIL single_empty got=%b exp=0", read_ready_o); end
   endtask

   task automatic test_overflow_underflow();
      for (int v = 65; v <= 68; v++) begin
         drive(1, 8'(v), 0);
         checks++; if (error_overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_fill_err v=%0d got=%b exp=0", v, error_overflow_o); end
         commit();
      end
      drive(1, 8'd88, 0);
      checks++; if (error_overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%b exp=1", error_overflow_o); end
      checks++; if (write_ready_o !== 1'b0) begin errors++; $display("FAIL ovf_write_ready got=%b exp=0", write_ready_o); end
      commit();
      drive(0, 0, 0);
      checks++; if (error_overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle got=%b exp=0", error_overflow_o); end
      for (int v = 65; v <= 68; v++) begin
         drive(0, 0, 1);
         checks++; if (read_data_o !== 8'(v)) begin errors++; $display("FAIL ovf_drain got=%0d exp=%0d", read_data_o, v); end
         commit();
      end
      drive(0, 0, 1);
      checks++; if (error_underflow_o !== 1'b1) begin errors++; $display("FAIL udf_pulse got=%b exp=1", error_underflow_o); end
      checks++; if (read_ready_o !== 1'b0) begin errors++; $display("FAIL udf_ready got=%b exp=0", read_ready_o); end
      commit();
      drive(0, 0, 0);
      checks++; if (error_underflow_o !== 1'b0) begin errors++; $display("FAIL udf_one_cycle got=%b exp=0", error_underflow_o); end
   endtask

   task automatic test_streaming();
      drive(1, 8'd65, 0); commit();
      for (int v = 66; v <= 74; v++) begin
         drive(1, 8'(v), 1);
         checks++; if (read_data_o !== 8'(v - 1)) begin errors++; $display("FAIL stream_data got=%0d exp=%0d", read_data_o, v - 1); end
         checks++; if ({error_underflow_o, error_overflow_o} !== 2'b00) begin errors++; $display("FAIL stream_err got=%b exp=00", {error_underflow_o, error_overflow_o}); end
         commit();
      end
      drive(0, 0, 1);
      checks++; if (read_data_o !== 8'd74) begin errors++; $display("FAIL stream_last got=%0d exp=74", read_data_o); end
      commit();
      drive(0, 0, 0);
      checks++; if (read_ready_o !== 1'b0) begin errors++; $display("FAIL stream_empty got=%b exp=0", read_ready_o); end
   endtask

   task automatic test_full_read_write();
      for (int v = 65; v <= 68; v++) begin drive(1, 8'(v), 0); commit(); end
      for (int v = 69; v <= 74; v++) begin
         drive(1, 8'(v), 1);
         checks++; if (read_data_o !== 8'(v - 4)) begin errors++; $display("FAIL full_rw_data got=%0d exp=%0d", read_data_o, v - 4); end
         checks++; if (error_overflow_o !== 1'b0) begin errors++; $display("FAIL full_rw_ovf got=%b exp=0", error_overflow_o); end
         commit();
      end
      for (int v = 71; v <= 74; v++) begin
         drive(0, 0, 1);
         checks++; if (read_data_o !== 8'(v)) begin errors++; $display("FAIL full_rw_drain got=%0d exp=%0d", read_data_o, v); end
         commit();
      end
      drive(0, 0, 0);
      checks++; if (read_ready_o !== 1'b0) begin errors++; $display("FAIL full_rw_empty got=%b exp=0", read_ready_o); end
   endtask

   task automatic test_wrap();
      for (int v = 65; v <= 68; v++) begin drive(1, 8'(v), 0); commit(); end
      drive(0, 0, 1);
      checks++; if (read_data_o !== 8'd65) begin errors++; $display("FAIL wrap_first got=%0d exp=65", read_data_o); end
      commit();
      drive(1, 8'd69, 0);
      checks++; if (error_overflow_o !== 1'b0) begin errors++; $display("FAIL wrap_w69_ovf got=%b exp=0", error_overflow_o); end
      commit();
      drive(1, 8'd70, 1);
      checks++; if (read_data_o !== 8'd66) begin errors++; $display("FAIL wrap_second got=%0d exp=66", read_data_o); end
      checks++; if (error_overflow_o !== 1'b0) begin errors++; $display("FAIL wrap_w70_ovf got=%b exp=0", error_overflow_o); end
      commit();
      for (int v = 67; v <= 70; v++) begin
         drive(0, 0, 1);
         checks++; if (read_data_o !== 8'(v)) begin errors++; $display("FAIL wrap_drain got=%0d exp=%0d", read_data_o, v); end
         checks++; if (error_underflow_o !== 1'b0) begin errors++; $display("FAIL wrap_udf got=%b exp=0", error_underflow_o); end
         commit();
      end
   endtask

   task automatic test_async_reset();
      for (int v = 1; v <= 3; v++) begin drive(1, 8'(v), 0); commit(); end
      @(posedge clock);
      #2;
      write_i = 1'b0; read_i = 1'b0;
      reset = 1'b1;
      #1;
      checks++; if (read_ready_o !== 1'b0) begin errors++; $display("FAIL areset_read_ready got=%b exp=0", read_ready_o); end
      checks++; if (write_ready_o !== 1'b1) begin errors++; $display("FAIL areset_write_ready got=%b exp=1", write_ready_o); end
      q.delete();
      @(negedge clock);
      reset = 1'b0;
      drive(1, 8'h5A, 0); commit();
      drive(0, 0, 1);
      checks++; if (read_data_o !== 8'h5A) begin errors++; $display("FAIL areset_roundtrip got=%h exp=5a", read_data_o); end
      commit();
      drive(0, 0, 0);
      checks++; if (read_ready_o !== 1'b0) begin errors++; $display("FAIL areset_empty got=%b exp=0", read_ready_o); end
   endtask

   task automatic test_random();
      logic       w;
      logic       r;
      logic [7:0] d;
      int         wpct;
      for (int i = 0; i < 600; i++) begin
         wpct = (i / 100) % 3 == 0 ? 80 : ((i / 100) % 3 == 1 ? 25 : 50);
         w = ($urandom_range(0, 99) < wpct);
         r = ($urandom_range(0, 99) < 100 - wpct);
         d = 8'($urandom);
         drive(w, d, r);
         checks++; if (read_ready_o !== (q.size() != 0)) begin errors++; $display("FAIL rnd_read_ready i=%0d got=%b size=%0d", i, read_ready_o, q.size()); end
         checks++; if (write_ready_o !== (q.size() < 4)) begin errors++; $display("FAIL rnd_write_ready i=%0d got=%b size=%0d", i, write_ready_o, q.size()); end
         checks++; if (error_underflow_o !== (r && q.size() == 0)) begin errors++; $display("FAIL rnd_udf i=%0d got=%b size=%0d", i, error_underflow_o, q.size()); end
         checks++; if (error_overflow_o !== (w && q.size() == 4 && !r)) begin errors++; $display("FAIL rnd_ovf i=%0d got=%b size=%0d", i, error_overflow_o, q.size()); end
         if (q.size() != 0) begin
            checks++; if (read_data_o !== q[0]) begin errors++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, read_data_o, q[0]); end
         end
`ifdef FIFO_LEVEL_EN
         checks++; if (level_o !== 3'(q.size())) begin errors++; $display("FAIL rnd_level i=%0d got=%0d exp=%0d", i, level_o, q.size()); end
`endif
         commit();
      end
   endtask

   initial begin
      reset = 1'b1; write_i = 1'b0; read_i = 1'b0; write_data_i = '0;
      test_reset();
      test_single();
      test_overflow_underflow();
      test_streaming();
      test_full_read_write();
      test_wrap();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
